debounce_edge_detect: RTL
=========================

Name: debounce_edge_detect

Overview:
- Consumes the registered single-bit level produced by the D-flop sampling stage.
- Resynchronises that level, rejects glitches shorter than STABLE_CYCLES samples, and outputs a clean level plus one-cycle rise and fall pulses.
- Used between a raw button or switch sampling flop and the control logic that counts or acts on presses.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised samples of the new value required before committing a change. Legal range: 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 8, width of the internal stability counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset; takes effect immediately on assertion, with synchronous deassertion assumed by the system.
- in_1  input  1  raw or flop-sampled level from the upstream stage; may bounce.
- out_1  output  1  debounced level, registered.
- rise_1  output  1  one-cycle pulse, high in the same cycle out_1 first reads 1.
- fall_1  output  1  one-cycle pulse, high in the same cycle out_1 first reads 0.
- busy_1  output  1  high while a candidate change is being qualified (state WAIT_HIGH or WAIT_LOW); decoded from the state register only.

Behaviour:
- Synchroniser: sync_a <= in_1; sync_s <= sync_a. The FSM uses only sync_s.
- Reset (rst_n=0, asynchronous):
  - sync_a, sync_s, out_1, rise_1, fall_1 = 0.
  - cnt = 0; state = IDLE_LOW; busy_1 = 0.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - sync_s=1 -> WAIT_HIGH, cnt<=1.
  - else stay, cnt<=0.
- WAIT_HIGH:
  - sync_s=0 -> IDLE_LOW, cnt<=0. Glitch rejected; no pulse; out_1 stays 0.
  - sync_s=1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, out_1<=1, rise_1<=1, cnt<=0.
  - sync_s=1 otherwise -> cnt<=cnt+1.
- IDLE_HIGH / WAIT_LOW: mirror of IDLE_LOW / WAIT_HIGH with polarity inverted. The commit sets out_1<=0 and fall_1<=1.
- Pulses: rise_1 and fall_1 default to 0 every cycle unless set by a commit. They are never high together, and never high for two consecutive cycles.
- Latency: an in_1 transition captured at edge k (into sync_a) commits at edge k+STABLE_CYCLES+1. With default 4, out_1 changes 5 edges after in_1 is captured.
- Minimum accepted pulse width: STABLE_CYCLES consecutive sync_s samples of the new value. Any shorter excursion is ignored entirely.
- Counter: never exceeds STABLE_CYCLES-1 and never wraps. CNT_WIDTH must hold STABLE_CYCLES-1 without overflow.
- Reset mid-qualification: an in-progress WAIT is abandoned and out_1 forces 0 immediately.
  - After release with in_1 held 1, a normal rise qualification runs and rise_1 fires once.
- in_1 held constant: no pulses and no state change after the initial settle.
- Toggling in_1 every cycle: out_1 never changes; busy_1 may toggle.

Test Plan:
- Reset with in_1=0, then hold in_1=0 for 20 cycles -> out_1=0, rise_1=fall_1=0, busy_1=0 throughout.
- Step in_1 0->1, captured at edge 10, held -> busy_1 high from edge 12; out_1=1 and rise_1=1 at edge 15 only; rise_1=0 at edge 16; busy_1=0 from edge 15.
- From steady out_1=1, drop in_1 to 0 for 3 cycles, then back to 1 -> out_1 stays 1; no fall_1; busy_1 pulses.
  - Repeat with a 4-cycle low -> fall_1 fires exactly once; out_1=0.
- Bounce pattern 1,0,1,1,0,1,1,1,1,1 on in_1 -> single rise_1, asserted 5 edges after the capture of the final sustained 1 run's first sample.
- Assert rst_n=0 while busy_1=1 in WAIT_HIGH -> all outputs 0 within the same cycle (asynchronous).
  - Release with in_1=1 -> rise_1 fires once, 5 edges after the first capture.
- STABLE_CYCLES=2 build: a 1-sample glitch is rejected; a 2-sample high commits 3 edges after capture.

Source files
------------

// File: rtl/debounce_edge_detect.sv
// Two-flop resynchroniser followed by a four-state debounce FSM.
// Produces a registered clean level plus one-cycle rise/fall pulses.
module debounce_edge_detect #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_1,
    output logic out_1,
    output logic rise_1,
    output logic fall_1,
    output logic busy_1
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // Count value on which the STABLE_CYCLES-th matching sample commits.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync_a;
    logic                 sync_s;
    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 out_next;
    logic                 rise_next;
    logic                 fall_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_s <= 1'b0;
        end else begin
            sync_a <= in_1;
            sync_s <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE_LOW;
            cnt    <= '0;
            out_1  <= 1'b0;
            rise_1 <= 1'b0;
            fall_1 <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            out_1  <= out_next;
            rise_1 <= rise_next;
            fall_1 <= fall_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = out_1;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (sync_s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    out_next   = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    out_next   = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy_1 = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule
